fifo_sram_drain: RTL



---
 rtl/fifo_drain_pkg.sv | 27 ++
 rtl/fifo_drain_skid.sv | 58 +++++
 rtl/fifo_sram_drain.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fifo_drain_pkg.sv
// fifo_sram drain stage: shared types, skid depth and counter width.
// Used by fifo_drain_skid and fifo_sram_drain.
package fifo_drain_pkg;

  typedef enum logic {
    S_HDR     = 1'b0,
    S_PAYLOAD = 1'b1
  } state_t;

  localparam int SKID_DEPTH = 2;
  localparam int CNT_W      = 32;
  localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

  // Module headers keep ctrl != 0; the first ctrl == 0 word opens the payload.
  function automatic state_t next_state(state_t s, logic ctrl_nz);
    next_state = s;
    unique case (s)
      S_HDR:     if (!ctrl_nz) next_state = S_PAYLOAD;
      S_PAYLOAD: if (ctrl_nz)  next_state = S_HDR;
    endcase
  endfunction

  function automatic logic is_eop(state_t s, logic ctrl_nz);
    return (s == S_PAYLOAD) && ctrl_nz;
  endfunction

endpackage

// File: rtl/fifo_drain_skid.sv
// Two-entry skid buffer that absorbs registered FIFO read data.
// Head reads as zero while empty.
module fifo_drain_skid
  import fifo_drain_pkg::*;
#(
  parameter int W = 72
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [OCC_W-1:0] occ,
  output logic [W-1:0]     head
);

  logic [W-1:0]     mem0;
  logic [W-1:0]     mem1;
  logic [OCC_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & (cnt != '0);
  assign do_push = push & (do_pop | (cnt < OCC_W'(SKID_DEPTH)));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt  <= '0;
      mem0 <= '0;
      mem1 <= '0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (cnt == '0) mem0 <= din;
          else           mem1 <= din;
          cnt <= cnt + OCC_W'(1);
        end
        2'b01: begin
          mem0 <= mem1;
          cnt  <= cnt - OCC_W'(1);
        end
        2'b11: begin
          if (cnt == OCC_W'(1)) begin
            mem0 <= din;
          end else begin
            mem0 <= mem1;
            mem1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign occ  = cnt;
  assign head = (cnt != '0) ? mem0 : '0;

endmodule

// File: rtl/fifo_sram_drain.sv
// Read stage for fifo_sram: reb issue, skid buffer, packet framing.
// Define FIFO_DRAIN_STATS_EN to build the pkt_count/word_count registers.
module fifo_sram_drain
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  drain_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic [CTRL_WIDTH-1:0] fifo_ctrl,
  input  logic                  fifo_empty,
  input  logic                  fifo_stall,
  output logic                  reb,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic                  in_pkt,
  output logic [CNT_W-1:0]      pkt_count,
  output logic [CNT_W-1:0]      word_count
);

  localparam int W = DATA_WIDTH + CTRL_WIDTH;

  logic [OCC_W-1:0] occ;
  logic [W-1:0]     head;
  logic             inflight;
  logic [2:0]       pend;
  logic             room;
  logic             allow;

  state_t state;
  state_t state_nxt;
  state_t f_state;
  state_t f_state_nxt;
  logic   f_open;
  logic   f_open_nxt;

  fifo_drain_skid #(
    .W(W)
  ) u_skid (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (inflight),
    .din    ({fifo_ctrl, fifo_data}),
    .pop    (out_wr),
    .occ    (occ),
    .head   (head)
  );

  assign out_ctrl = head[W-1:DATA_WIDTH];
  assign out_data = head[DATA_WIDTH-1:0];

  // The word leaving this cycle frees a slot, so streaming stays back-to-back.
  assign pend  = {1'b0, occ} + {2'b00, inflight};
  assign room  = pend < (3'd2 + {2'b00, out_wr});
  // With drain_en low, only fetch while the open packet's EOP is still unseen.
  assign allow = drain_en | (f_open & !inflight);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      inflight <= 1'b0;
      state    <= S_HDR;
      f_state  <= S_HDR;
      f_open   <= 1'b0;
    end else begin
      inflight <= reb;
      state    <= state_nxt;
      f_state  <= f_state_nxt;
      f_open   <= f_open_nxt;
    end
  end

  always_comb begin
    out_wr      = 1'b0;
    reb         = 1'b0;
    state_nxt   = state;
    f_state_nxt = f_state;
    f_open_nxt  = f_open;
    out_wr = reset_n & out_rdy & (occ != '0);
    reb    = reset_n & !fifo_empty & !fifo_stall & room & allow;
    if (out_wr) state_nxt = next_state(state, |out_ctrl);
    if (inflight) begin
      f_state_nxt = next_state(f_state, |fifo_ctrl);
      unique case (1'b1)
        (f_state == S_HDR):     f_open_nxt = 1'b1;
        (f_state == S_PAYLOAD): f_open_nxt = !(|fifo_ctrl);
      endcase
    end
  end

  assign in_pkt = f_open | (occ != '0) | inflight;

`ifdef FIFO_DRAIN_STATS_EN
  logic             eop_pop;
  logic [CNT_W-1:0] pkt_q;
  logic [CNT_W-1:0] word_q;

  assign eop_pop = out_wr & is_eop(state, |out_ctrl);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pkt_q  <= '0;
      word_q <= '0;
    end else begin
      if (out_wr)  word_q <= word_q + CNT_W'(1);
      if (eop_pop) pkt_q  <= pkt_q + CNT_W'(1);
    end
  end

  assign pkt_count  = pkt_q;
  assign word_count = word_q;
`else
  assign pkt_count  = '0;
  assign word_count = '0;
`endif

endmodule
